ex_mem_buf: RTL

EX_MEM_BUF -- requirements
Module: ex_mem_buf

---
 rtl/ex_mem_pkg.sv | 29 ++
 rtl/ex_mem_slot.sv | 34 +++
 rtl/ex_mem_buf.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline buffer: default widths, control
// bit positions and the occupancy state encoding.
package ex_mem_pkg;

  // Default datapath widths.
  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefRegAddrW  = 5;

  // ex_ctrl is {reg_write, mem_read, mem_write, branch}.
  localparam int unsigned CtrlW        = 4;
  localparam int unsigned CtrlRegWrite = 3;
  localparam int unsigned CtrlMemRead  = 2;
  localparam int unsigned CtrlMemWrite = 1;
  localparam int unsigned CtrlBranch   = 0;

  // Occupancy: no beat, head only, head plus skid.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHead  = 2'd1,
    StFull  = 2'd2
  } buf_state_e;

  // Width of one packed beat {alu_result, rd, ctrl, store_data}.
  function automatic int unsigned beat_width(input int unsigned data_w,
                                             input int unsigned addr_w);
    return 2 * data_w + addr_w + CtrlW;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One beat register: loads d_i when load_i is high, otherwise holds.
module ex_mem_slot #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;
  logic [Width-1:0] q_d;

  // Hold unless loaded.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end
  end

  // Beat storage, cleared to zero so outputs are never X after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/ex_mem_buf.sv
// EX/MEM pipeline buffer: a head register feeding MEM plus one skid register,
// so ex_ready can be registered without losing a beat when MEM stalls.
module ex_mem_buf
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned REG_ADDR_W = DefRegAddrW
) (
  input  logic                  clk,
  input  logic                  rst,
  // EX side
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic [CtrlW-1:0]      ex_ctrl,
  input  logic [DATA_WIDTH-1:0] ex_store_data,
  input  logic                  flush,
  // MEM side
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [DATA_WIDTH-1:0] mem_alu_result,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [CtrlW-1:0]      mem_ctrl,
  output logic [DATA_WIDTH-1:0] mem_store_data,
  // Status
  output logic                  branch_taken,
  output logic [15:0]           beat_count
);

  localparam int unsigned BeatW = beat_width(DATA_WIDTH, REG_ADDR_W);

  buf_state_e       state_q, state_d;
  logic             ex_ready_q, ex_ready_d;
  logic             branch_q, branch_d;
  logic [15:0]      count_q, count_d;

  logic             accept;
  logic             deliver;
  logic             head_load;
  logic             skid_load;
  logic             head_from_skid;
  logic [BeatW-1:0] in_beat;
  logic [BeatW-1:0] head_d;
  logic [BeatW-1:0] head_q;
  logic [BeatW-1:0] skid_q;

  assign in_beat   = {alu_result, ex_rd, ex_ctrl, ex_store_data};
  assign mem_valid = (state_q != StEmpty);
  assign accept    = ex_valid & ex_ready_q;
  assign deliver   = mem_valid & mem_ready;

  // Occupancy transitions and slot load controls; flush overrides everything.
  always_comb begin
    state_d        = state_q;
    head_load      = 1'b0;
    skid_load      = 1'b0;
    head_from_skid = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StHead;
          head_load = 1'b1;
        end
      end
      StHead: begin
        if (accept && deliver) begin
          head_load = 1'b1;
        end else if (accept) begin
          state_d   = StFull;
          skid_load = 1'b1;
        end else if (deliver) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        // ex_ready is low here, so only a deliver can happen.
        if (deliver) begin
          state_d        = StHead;
          head_load      = 1'b1;
          head_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = StEmpty;
      end
    endcase
    if (flush) begin
      state_d   = StEmpty;
      head_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  // Registered ready: derived from next occupancy, never from mem_ready directly.
  always_comb begin
    ex_ready_d = (state_d != StFull);
  end

  // Taken-branch pulse and delivered-beat counter next state.
  always_comb begin
    branch_d = accept & ex_ctrl[CtrlBranch] & alu_zero & ~flush;
    count_d  = count_q;
    if (deliver && !flush) begin
      count_d = count_q + 16'd1;
    end
  end

  // New beats enter the head directly unless the skid is draining into it.
  always_comb begin
    head_d = in_beat;
    if (head_from_skid) begin
      head_d = skid_q;
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StEmpty;
      ex_ready_q <= 1'b1;
      branch_q   <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= ex_ready_d;
      branch_q   <= branch_d;
      count_q    <= count_d;
    end
  end

  ex_mem_slot #(
    .Width (BeatW)
  ) u_head (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (head_load),
    .d_i    (head_d),
    .q_o    (head_q)
  );

  ex_mem_slot #(
    .Width (BeatW)
  ) u_skid (
    .clk_i  (clk),
    .rst_i  (rst),
    .load_i (skid_load),
    .d_i    (in_beat),
    .q_o    (skid_q)
  );

  assign {mem_alu_result, mem_rd, mem_ctrl, mem_store_data} = head_q;
  assign ex_ready     = ex_ready_q;
  assign branch_taken = branch_q;
  assign beat_count   = count_q;

endmodule
